// File: rtl/muxn_rr_stream.sv
// N-channel registered stream selector: fixed-select or round-robin arbitration
// into a single output register slot with valid/ready handshaking.
module muxn_rr_stream #(
  parameter int DW   = 8,
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  output logic [SELW-1:0]   out_ch,
  input  logic              out_ready
);

  localparam int PADN = 1 << SELW;

  logic [SELW-1:0] ptr_reg, ptr_next;
  logic            out_valid_reg;
  logic [DW-1:0]   out_data_reg;
  logic [SELW-1:0] out_ch_reg;

  logic [DW-1:0]   ch_data [NCH];
  logic [PADN-1:0] valid_pad;
  logic            fx_hit, rr_hit, grant_valid;
  logic [SELW-1:0] rr_idx, scan_idx, grant;
  logic [SELW:0]   scan_sum;
  logic            space, load;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*DW +: DW];
      assign in_ready[gi] = !rst && space && grant_valid && (grant == SELW'(gi));
    end
  endgenerate

  // Padding in_valid to a power of two lets sel/scan indices address it
  // safely; out-of-range channels read as never valid.
  always_comb begin
    valid_pad          = '0;
    valid_pad[NCH-1:0] = in_valid;
    fx_hit   = ({1'b0, sel} < (SELW+1)'(NCH)) && valid_pad[sel];
    rr_hit   = 1'b0;
    rr_idx   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_sum = {1'b0, ptr_reg} + (SELW+1)'(k);
      if (scan_sum >= (SELW+1)'(NCH)) begin
        scan_sum = scan_sum - (SELW+1)'(NCH);
      end
      scan_idx = scan_sum[SELW-1:0];
      if (!rr_hit && valid_pad[scan_idx]) begin
        rr_hit = 1'b1;
        rr_idx = scan_idx;
      end
    end
    grant_valid = mode ? rr_hit : fx_hit;
    grant       = mode ? rr_idx : sel;
  end

  always_comb begin
    space    = !out_valid_reg || out_ready;
    load     = grant_valid && space;
    ptr_next = ptr_reg;
    if (load && mode) begin
      ptr_next = (grant == SELW'(NCH-1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else begin
      ptr_reg <= ptr_next;
      if (load) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[grant];
        out_ch_reg    <= grant;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_muxn_rr_stream.sv
// Bench for muxn_rr_stream: reference-model scoreboard on a 4-channel instance
// plus directed checks, and a 3-channel instance for non-power-of-two wrap.
module tb_muxn_rr_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_ch3;
  logic        out_ready3;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
  } beat_t;
  beat_t sb_q[$];
  beat_t sb_b;
  int    m_ptr = 0;
  int    m_g;
  int    m_idx;
  logic  m_space;
  logic [3:0] m_rdy;
  logic  mon_en = 1'b0;

  always #5 clk = ~clk;

  muxn_rr_stream #(.DW(8), .NCH(4)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  muxn_rr_stream #(.DW(8), .NCH(3)) u_dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: predict the grant from a bench-side pointer, check in_ready,
  // push accepted beats and compare them against the output register.
  always @(negedge clk) begin
    if (mon_en) begin
      check("sb_out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
      if (sb_q.size() != 0) begin
        check("sb_out_data", {24'd0, out_data}, {24'd0, sb_q[0].data});
        check("sb_out_ch", {30'd0, out_ch}, {30'd0, sb_q[0].ch});
      end
      m_g = -1;
      if (!mode) begin
        if (in_valid[sel]) m_g = int'(sel);
      end else begin
        for (int k = 0; k < 4; k++) begin
          m_idx = (m_ptr + k) % 4;
          if (m_g < 0 && in_valid[m_idx]) m_g = m_idx;
        end
      end
      m_space = (sb_q.size() == 0) || out_ready;
      m_rdy = 4'b0000;
      if (!rst && m_space && m_g >= 0) m_rdy[m_g] = 1'b1;
      check("sb_in_ready", {28'd0, in_ready}, {28'd0, m_rdy});
      if (rst) begin
        sb_q.delete();
        m_ptr = 0;
      end else begin
        if (out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
        if (m_rdy != 4'b0000) begin
          sb_b.data = in_data[m_g*8 +: 8];
          sb_b.ch   = 2'(m_g);
          sb_q.push_back(sb_b);
          if (mode) m_ptr = (m_g + 1) % 4;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mode = 1'b1; sel = 2'd0;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11}; in_valid = 4'hF; out_ready = 1'b1;
    mode3 = 1'b1; sel3 = 2'd0; in_data3 = {8'hA2, 8'hA1, 8'hA0};
    in_valid3 = 3'b000; out_ready3 = 1'b1;

    // Reset with every channel valid
    @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_ch", {30'd0, out_ch}, 32'd0);
    check("rst_in_ready", {28'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;

    // Round-robin over all four channels, then over 1010
    @(negedge clk);
    check("rr_first_grant", {28'd0, in_ready}, 32'b0001);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_seq_all", {30'd0, out_ch}, 32'(i % 4));
    end
    step();
    in_valid = 4'b1010;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_seq_1010", {30'd0, out_ch}, (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Fixed select
    step();
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF;
    @(negedge clk);
    check("fx_in_ready_sel2", {28'd0, in_ready}, 32'b0100);
    @(negedge clk);
    check("fx_data_sel2", {24'd0, out_data}, 32'h33);
    check("fx_ch_sel2", {30'd0, out_ch}, 32'd2);
    step();
    sel = 2'd3;
    @(negedge clk);
    check("fx_in_ready_sel3", {28'd0, in_ready}, 32'b1000);
    @(negedge clk);
    check("fx_data_sel3", {24'd0, out_data}, 32'h44);

    // Backpressure hold of a beat from ch1
    step();
    mode = 1'b1; in_valid = 4'b0010; in_data = {8'h44, 8'h33, 8'hA5, 8'h11};
    step();
    out_ready = 1'b0; in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_data", {24'd0, out_data}, 32'hA5);
      check("bp_hold_ch", {30'd0, out_ch}, 32'd1);
      check("bp_in_ready", {28'd0, in_ready}, 32'd0);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_next_grant", {28'd0, in_ready}, 32'b0100);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_next_ch", {30'd0, out_ch}, 32'd2);
    check("bp_next_data", {24'd0, out_data}, 32'h33);

    // Reset while a beat is held
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 4'b1100; out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_grant", {28'd0, in_ready}, 32'b0100);
    @(negedge clk);
    check("mid_rst_ch", {30'd0, out_ch}, 32'd2);

    // Three-channel wrap and out-of-range select
    step();
    in_valid3 = 3'b111;
    @(negedge clk);
    check("n3_first_grant", {29'd0, in_ready3}, 32'b001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("n3_rr_seq", {30'd0, out_ch3}, 32'(i % 3));
    end
    step();
    mode3 = 1'b0; sel3 = 2'd3;
    @(negedge clk);
    check("n3_sel3_in_ready", {29'd0, in_ready3}, 32'd0);
    check("n3_held_valid", {31'd0, out_valid3}, 32'd1);
    @(negedge clk);
    check("n3_drained_valid", {31'd0, out_valid3}, 32'd0);

    // Random traffic checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      step();
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muxn_rr_stream.md
# muxn_rr_stream

Parametrised N-channel, W-bit stream multiplexer that generalises the 4-to-1 select muxes into a registered, handshaked channel selector. It supports two modes: fixed-select (external `sel`) and round-robin arbitration among valid channels. It sits between multiple producer streams and a single consumer, presenting one registered output beat per cycle with valid/ready backpressure.

## Interface
- `DW`, default 8: data width per channel, ≥1.
- `NCH`, default 4: channel count, ≥2; need not be a power of two.
- `SELW`, default `$clog2(NCH)`: select/channel-index width; derived, not overridden.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `mode` input 1: 0 = fixed-select via `sel`, 1 = round-robin.
- `sel` input SELW: channel chosen in fixed mode; ignored in round-robin mode.
- `in_data` input NCH*DW: channel i occupies bits [i*DW +: DW].
- `in_valid` input NCH: per-channel beat valid.
- `in_ready` output NCH: per-channel accept, combinational, one-hot or zero.
- `out_data` output DW: registered selected beat.
- `out_valid` output 1: registered; `out_data` is valid.
- `out_ch` output SELW: registered index of the channel that sourced `out_data`.
- `out_ready` input 1: consumer accept.

## Operation
- Output stage is a single register slot. `space = !out_valid || out_ready`.
- Grant (combinational, at most one channel):
  - Fixed mode: grant `sel` when `sel < NCH` and `in_valid[sel]`. Otherwise no grant. `sel ≥ NCH` never grants and never raises any `in_ready`.
  - Round-robin mode: grant the first i with `in_valid[i]`, scanning `ptr, ptr+1, …, NCH-1, 0, …, ptr-1`. No grant when `in_valid == 0`.
- `in_ready[g] = space` for granted g; all other `in_ready` bits are 0. `in_ready` never depends on `in_valid` of other channels in fixed mode.
- Load = grant exists && `space`. On load: `out_data ← in_data[g]`, `out_ch ← g`, `out_valid ← 1`.
- No load && `out_ready`: `out_valid ← 0`. `out_data`/`out_ch` keep their value.
- No load && !`out_ready`: all output registers hold. `out_data`/`out_ch` must be stable while `out_valid && !out_ready`.
- Round-robin pointer `ptr` (range 0..NCH-1):
  - Updates only on load in mode 1: `ptr ← g+1`, wrapping from NCH-1 to 0 without visiting indices ≥ NCH.
  - Fixed-mode loads never change `ptr`.
- Mode or `sel` changes take effect on the grant in the same cycle. A beat already in the output register is unaffected.

## Timing
- Reset (`rst=1` at a clock edge): `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0`.
- While `rst=1`, all `in_ready` bits are forced to 0. A beat held at reset assertion is discarded, with no handshake to the consumer.
- Latency: input accept at edge k → `out_valid=1` with that data after edge k (visible in cycle k+1).
- Throughput: one beat per cycle when `out_ready=1` continuously. Back-to-back loads and unloads in the same cycle are required.
- Backpressure: when `out_valid=1` and `out_ready=0`, all `in_ready=0`. Nothing is dropped and nothing is duplicated.
- No combinational path from `out_ready` to `out_data`/`out_valid`. A combinational path from `out_ready` to `in_ready` is allowed.

## Test plan
- Reset: drive `rst=1` for 2 cycles with all inputs valid → `out_valid=0`, `out_data=0`, `out_ch=0`, `in_ready=0000`. After release, mode 1, first grant is ch0.
- Fixed select (NCH=4, DW=8): `mode=0`, `sel=2`, `in_data` ch0..3 = 0x11/0x22/0x33/0x44, all valid, `out_ready=1` → `in_ready=0100` and `out_data=0x33`, `out_ch=2` one cycle later. Then `sel=3` → 0x44 on the next beat.
- Round-robin fairness: `mode=1`, `in_valid=1111`, `out_ready=1` for 8 cycles → `out_ch` sequence 0,1,2,3,0,1,2,3. With `in_valid=1010` → 1,3,1,3.
- Backpressure hold: load 0xA5 from ch1, then `out_ready=0` for 3 cycles with other channels valid → `out_data=0xA5`, `out_ch=1` stable, `in_ready=0000`. On `out_ready=1`, the next beat comes from ch2 or above per `ptr=2`.
- Non-power-of-two wrap: NCH=3, `mode=1`, all valid → `out_ch` 0,1,2,0. `mode=0`, `sel=3` → no grant, `out_valid` drops after the held beat drains.
- Reset mid-stream: `out_valid=1`, `out_ready=0`, assert `rst` for 1 cycle → `out_valid=0`, `ptr=0`. The first post-reset round-robin grant is the lowest valid channel.
